sand_stack_reader: RTL and testbench

SAND_STACK_READER -- requirements
Module: sand_stack_reader

---
 rtl/sand_stack_reader.sv | 144 ++++++++++++++
 tb/tb_sand_stack_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sand_stack_reader.sv
// Snapshots a ROWS x COLS sand-stack array on start and streams the active region in raster order.
// Latency: first beat valid 1 cycle after the start edge; done_o pulses 1 cycle after the last transfer.
// Backpressure: valid/ready; a stalled beat holds every beat output until cell_ready_i is seen.
module sand_stack_reader #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int GRID_SIZE = ROWS * COLS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [GRID_SIZE*3-1:0]      stack_i,
    input  logic [GRID_SIZE-1:0]        collapse_i,
    input  logic [$clog2(ROWS+1)-1:0]   activeRows_i,
    input  logic [$clog2(COLS+1)-1:0]   activeCols_i,
    input  logic                        cell_ready_i,
    output logic                        cell_valid_o,
    output logic [2:0]                  cell_data_o,
    output logic [4:0]                  cell_x_o,
    output logic [4:0]                  cell_y_o,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        stable_o,
    output logic                        done_o
);

    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    localparam int IW = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t          state;
    logic [2:0]      snap [GRID_SIZE];
    logic [RW-1:0]   rows_q;
    logic [CW-1:0]   cols_q;
    logic [CW-1:0]   x_q;
    logic [RW-1:0]   y_q;

    logic [RW-1:0]   rows_c;
    logic [CW-1:0]   cols_c;
    logic            stable_c;
    logic [CW-1:0]   nx;
    logic [RW-1:0]   ny;
    logic [IW-1:0]   nidx;
    logic            nlast;

    assign cell_x_o = 5'(x_q);
    assign cell_y_o = 5'(y_q);

    always_comb begin
        rows_c = (activeRows_i > RW'(ROWS)) ? RW'(ROWS) : activeRows_i;
        cols_c = (activeCols_i > CW'(COLS)) ? CW'(COLS) : activeCols_i;

        // Collapse flags outside the clamped active window never affect stability.
        stable_c = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((RW'(r) < rows_c) && (CW'(c) < cols_c) && collapse_i[r*COLS+c]) begin
                    stable_c = 1'b0;
                end
            end
        end

        nx = x_q + CW'(1);
        ny = y_q;
        if (x_q == cols_q - CW'(1)) begin
            nx = '0;
            ny = y_q + RW'(1);
        end
        nidx  = IW'(ny) * IW'(COLS) + IW'(nx);
        nlast = (nx == cols_q - CW'(1)) && (ny == rows_q - RW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            for (int i = 0; i < GRID_SIZE; i++) begin
                snap[i] <= '0;
            end
            rows_q       <= '0;
            cols_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            cell_valid_o <= 1'b0;
            cell_data_o  <= '0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
            stable_o     <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < GRID_SIZE; i++) begin
                            snap[i] <= stack_i[i*3 +: 3];
                        end
                        rows_q   <= rows_c;
                        cols_q   <= cols_c;
                        x_q      <= '0;
                        y_q      <= '0;
                        busy_o   <= 1'b1;
                        stable_o <= stable_c;
                        if ((rows_c != '0) && (cols_c != '0)) begin
                            // First beat comes straight from the input bus, identical to the snapshot.
                            state        <= STREAM;
                            cell_valid_o <= 1'b1;
                            cell_data_o  <= stack_i[2:0];
                            last_o       <= (rows_c == RW'(1)) && (cols_c == CW'(1));
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                STREAM: begin
                    if (cell_valid_o && cell_ready_i) begin
                        if (last_o) begin
                            state        <= DONE;
                            cell_valid_o <= 1'b0;
                            last_o       <= 1'b0;
                        end else begin
                            x_q         <= nx;
                            y_q         <= ny;
                            cell_data_o <= snap[nidx];
                            last_o      <= nlast;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sand_stack_reader.sv
// Randomized bench for sand_stack_reader: per-frame expected beat queue built from the snapshot and active window.
module tb_sand_stack_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [74:0] stack_i = '0;
    logic [24:0] collapse_i = '0;
    logic [2:0]  activeRows_i = '0;
    logic [2:0]  activeCols_i = '0;
    logic        cell_ready_i = 1'b0;
    logic        cell_valid_o;
    logic [2:0]  cell_data_o;
    logic [4:0]  cell_x_o;
    logic [4:0]  cell_y_o;
    logic        last_o;
    logic        busy_o;
    logic        stable_o;
    logic        done_o;

    int n_checks = 0;
    int n_errors = 0;

    sand_stack_reader #(.ROWS(5), .COLS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stack_i      (stack_i),
        .collapse_i   (collapse_i),
        .activeRows_i (activeRows_i),
        .activeCols_i (activeCols_i),
        .cell_ready_i (cell_ready_i),
        .cell_valid_o (cell_valid_o),
        .cell_data_o  (cell_data_o),
        .cell_x_o     (cell_x_o),
        .cell_y_o     (cell_y_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .stable_o     (stable_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {cell_valid_o, last_o, busy_o, done_o, stable_o, cell_data_o, cell_x_o, cell_y_o};
    endfunction

    // dmode: 0 random data, 1 data = i mod 4.  cmode: 0 random, 1 none, 2 only (4,4), 3 only (1,1).
    task automatic run_frame(input int r, input int c, input int rdy_pct, input bit perturb,
                             input int abort_after, input int dmode, input int cmode);
        int          st [25];
        bit          cl [25];
        logic [13:0] q [$];
        logic [13:0] b;
        int          rc, cc, exp_stab, cyc, last_evt, n_xfer;
        bit          done_seen;

        for (int i = 0; i < 25; i++) begin
            st[i] = (dmode == 1) ? (i % 4) : int'($urandom_range(7));
            case (cmode)
                0:       cl[i] = ($urandom_range(3) == 0);
                2:       cl[i] = (i == 24);
                3:       cl[i] = (i == 6);
                default: cl[i] = 1'b0;
            endcase
        end
        rc = (r > 5) ? 5 : r;
        cc = (c > 5) ? 5 : c;
        exp_stab = 1;
        for (int y = 0; y < rc; y++) begin
            for (int x = 0; x < cc; x++) begin
                if (cl[y*5+x]) exp_stab = 0;
                b = {((x == cc-1) && (y == rc-1)), 3'(st[y*5+x]), 5'(x), 5'(y)};
                q.push_back(b);
            end
        end

        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            stack_i[i*3 +: 3] = 3'(st[i]);
            collapse_i[i]     = cl[i];
        end
        activeRows_i = 3'(r);
        activeCols_i = 3'(c);
        start_i      = 1'b1;
        cell_ready_i = ($urandom_range(99) < rdy_pct);
        cyc = 0; last_evt = 0; n_xfer = 0; done_seen = 1'b0;

        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && n_xfer == abort_after) begin
                start_i      = 1'b0;
                cell_ready_i = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk("rst_async_zero", 32'(all_outs()), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_hold", 32'(all_outs()), 0);
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_idle", {cell_valid_o, busy_o, done_o}, 0);
                end
                return;
            end
            if (cyc == 1) begin
                chk("busy_start", busy_o, 1);
                chk("stable", stable_o, exp_stab);
                chk("first_valid", cell_valid_o, q.size() > 0);
            end
            if (done_o) begin
                done_seen = 1'b1;
                chk("done_lat", cyc - last_evt, 2);
                chk("beats_left", q.size(), 0);
                chk("busy_clr", busy_o, 0);
                chk("stable_hold", stable_o, exp_stab);
            end
            if (cell_valid_o) begin
                if (q.size() == 0) chk("extra_beat", 1, 0);
                else               chk("beat", {last_o, cell_data_o, cell_x_o, cell_y_o}, q[0]);
            end
            start_i = perturb && !done_seen;
            if (perturb) begin
                stack_i      = {$urandom, $urandom, $urandom};
                collapse_i   = 25'($urandom);
                activeRows_i = 3'($urandom_range(7));
                activeCols_i = 3'($urandom_range(7));
            end
            cell_ready_i = ($urandom_range(99) < rdy_pct);
            if (cell_valid_o && cell_ready_i && q.size() > 0) begin
                void'(q.pop_front());
                n_xfer++;
                last_evt = cyc;
            end
        end
        if (!done_seen) chk("timeout", 0, 1);
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("quiet", {cell_valid_o, busy_o, done_o}, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(all_outs()), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_beat", {cell_valid_o, busy_o}, 0);

        run_frame(5, 5, 100, 1'b0, -1, 1, 1);
        run_frame(2, 3, 50,  1'b0, -1, 0, 0);
        run_frame(3, 3, 100, 1'b0, -1, 0, 2);
        run_frame(3, 3, 100, 1'b0, -1, 0, 3);
        run_frame(4, 5, 70,  1'b1, -1, 0, 0);
        run_frame(5, 0, 100, 1'b0, -1, 0, 0);
        run_frame(0, 3, 100, 1'b1, -1, 0, 0);
        run_frame(5, 5, 100, 1'b0, 7,  1, 0);
        run_frame(5, 5, 100, 1'b0, -1, 0, 0);
        run_frame(7, 6, 80,  1'b0, -1, 0, 0);
        run_frame(1, 1, 40,  1'b0, -1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            run_frame($urandom_range(7), $urandom_range(7), $urandom_range(100, 30),
                      1'($urandom_range(1)), -1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
